// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed seven-segment scan driver.
//   SEG_BLANK : active-low pattern with every segment off
//   NDIG      : number of digits scanned
//   state_e   : scan state machine encoding (idle, digit lit, inter-digit blanking)
package seg_pkg;

  localparam logic [6:0]  SEG_BLANK = 7'h7F;
  localparam int unsigned NDIG      = 8;

  typedef enum logic [1:0] {
    StIdle,
    StShow,
    StGuard
  } state_e;

endpackage

// File: rtl/tick_gen.sv
// Period prescaler for the scan driver.
// Counts 0..load_i-1 while en_i is high and pulses tc_o combinationally on the
// last count; the counter then returns to 0. clr_i forces the count to 0.
//   clk    : clock
//   rst    : asynchronous active-high reset
//   clr_i  : synchronous clear (wins over en_i)
//   en_i   : count enable
//   load_i : period length in cycles (must be >= 1 while en_i is high)
//   tc_o   : terminal-count pulse, high during the final cycle of the period
module tick_gen #(
  parameter int unsigned Width = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [Width-1:0] load_i,
  output logic             tc_o
);

  logic [Width-1:0] cnt_q, cnt_d, cnt_inc;

  // cnt_q never exceeds load_i - 1, so the increment cannot wrap.
  assign cnt_inc = cnt_q + Width'(1);
  assign tc_o    = en_i && (cnt_inc == load_i);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tc_o ? '0 : cnt_inc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed driver for an 8-digit common-anode seven-segment display.
// Each digit is lit for DIV cycles, followed by GUARD blank cycles, then the
// next digit (wrapping 7 -> 0). Patterns live in an 8 x 7-bit register store.
//   clk    : clock
//   rst    : asynchronous active-high reset (blanks display and store)
//   en     : scan enable; low blanks the display and parks the scan
//   wr_en  : pattern store write strobe
//   wr_idx : digit written
//   wr_seg : active-low segment pattern written
//   an     : active-low digit enables (registered)
//   seg    : active-low segment lines (registered)
//   idx    : digit currently scheduled
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned DIV   = 50000,
  parameter int unsigned GUARD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       wr_en,
  input  logic [2:0] wr_idx,
  input  logic [6:0] wr_seg,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic [2:0] idx
);

  // Sized by DIV; widened only if GUARD happens to exceed DIV.
  localparam int unsigned PMax = (DIV > GUARD) ? DIV : GUARD;
  localparam int unsigned CntW = $clog2(PMax + 1);

  state_e     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] an_q, an_d;
  logic [6:0] seg_q, seg_d;
  logic [6:0] store_q [NDIG];

  logic [CntW-1:0] load;
  logic            tick_en;
  logic            tc;

  assign load    = (state_q == StShow) ? CntW'(DIV) : CntW'(GUARD);
  assign tick_en = en && (state_q != StIdle);

  tick_gen #(
    .Width (CntW)
  ) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (!en),
    .en_i   (tick_en),
    .load_i (load),
    .tc_o   (tc)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      StIdle: begin
        if (en) state_d = StShow;
      end
      StShow: begin
        if (!en) begin
          state_d = StIdle;
        end else if (tc) begin
          if (GUARD == 0) begin
            idx_d = idx_q + 3'd1;
          end else begin
            state_d = StGuard;
          end
        end
      end
      StGuard: begin
        if (!en) begin
          state_d = StIdle;
        end else if (tc) begin
          state_d = StShow;
          idx_d   = idx_q + 3'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so they switch on the same edge as
  // the state register. The store is read before this edge's write lands, so a
  // write coinciding with a digit switch shows up one cycle later.
  always_comb begin
    an_d  = 8'hFF;
    seg_d = SEG_BLANK;
    if (state_d == StShow) begin
      an_d  = ~(8'd1 << idx_d);
      seg_d = store_q[idx_d];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= 3'd0;
      an_q    <= 8'hFF;
      seg_q   <= SEG_BLANK;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NDIG; i++) begin
        store_q[i] <= SEG_BLANK;
      end
    end else if (wr_en) begin
      store_q[wr_idx] <= wr_seg;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign idx = idx_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver with DIV=4, GUARD=2. The stimulus
// process drives one cycle at a time and queues the hand-computed an/seg that
// must follow each edge; the monitor pops and compares on every falling edge.
module tb_seg_scan_driver;

  logic       clk;
  logic       rst;
  logic       en;
  logic       wr_en;
  logic [2:0] wr_idx;
  logic [6:0] wr_seg;
  logic [7:0] an;
  logic [6:0] seg;
  logic [2:0] idx;

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  seg_scan_driver #(
    .DIV   (4),
    .GUARD (2)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .wr_en  (wr_en),
    .wr_idx (wr_idx),
    .wr_seg (wr_seg),
    .an     (an),
    .seg    (seg),
    .idx    (idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: one expected entry per edge, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (an !== e.an || seg !== e.seg) begin
        errors++;
        $display("FAIL scan_out t=%0t: got an=%h seg=%h, want an=%h seg=%h",
                 $time, an, seg, e.an, e.seg);
      end
    end
  end

  // At most one digit enabled at any time.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      assert ($countones(~an) <= 1)
      else begin
        errors++;
        $display("FAIL an_onehot t=%0t: got an=%h, want at most one low bit", $time, an);
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  // One clock: drive inputs at the falling edge, queue expected post-edge outputs.
  task automatic cyc(input logic e, input logic w, input logic [2:0] wi, input logic [6:0] ws,
                     input logic [7:0] ea, input logic [6:0] es);
    exp_t x;
    @(negedge clk);
    rst    = 1'b0;
    en     = e;
    wr_en  = w;
    wr_idx = wi;
    wr_seg = ws;
    @(posedge clk);
    #1;
    x.an  = ea;
    x.seg = es;
    exp_q.push_back(x);
  endtask

  task automatic lit(input int d, input logic [6:0] s, input int n);
    logic [7:0] a;
    a = ~(8'd1 << d);
    for (int k = 0; k < n; k++) cyc(1'b1, 1'b0, 3'd0, 7'h00, a, s);
  endtask

  task automatic gap();
    for (int k = 0; k < 2; k++) cyc(1'b1, 1'b0, 3'd0, 7'h00, 8'hFF, 7'h7F);
  endtask

  initial begin
    rst    = 1'b0;
    en     = 1'b0;
    wr_en  = 1'b0;
    wr_idx = 3'd0;
    wr_seg = 7'h00;

    // Asynchronous reset before any clock edge.
    #3 rst = 1'b1;
    #1;
    chk("reset_an", an, 8'hFF);
    chk("reset_seg", {1'b0, seg}, 8'h7F);
    chk("reset_idx", {5'd0, idx}, 8'h00);

    // Blank store: full scan, FE for 4 cycles then FF FF guard, wrap to digit 0.
    for (int d = 0; d < 8; d++) begin
      lit(d, 7'h7F, 4);
      gap();
    end
    lit(0, 7'h7F, 2);
    cyc(1'b0, 1'b0, 3'd0, 7'h00, 8'hFF, 7'h7F);  // en low -> idle next edge

    // Load patterns while idle, then resume digit 0 for a full period.
    cyc(1'b0, 1'b1, 3'd0, 7'h40, 8'hFF, 7'h7F);
    cyc(1'b0, 1'b1, 3'd7, 7'h78, 8'hFF, 7'h7F);
    lit(0, 7'h40, 4);
    gap();
    for (int d = 1; d < 7; d++) begin
      lit(d, 7'h7F, 4);
      gap();
    end
    lit(7, 7'h78, 4);
    gap();
    lit(0, 7'h40, 4);
    gap();
    lit(1, 7'h7F, 4);
    gap();

    // Live write to the lit digit: visible one edge after the write edge.
    lit(2, 7'h7F, 1);
    cyc(1'b1, 1'b1, 3'd2, 7'h24, 8'hFB, 7'h7F);
    lit(2, 7'h24, 2);
    gap();

    // Write on the same edge digit 3 switches in: pre-write value first.
    cyc(1'b1, 1'b1, 3'd3, 7'h12, 8'hF7, 7'h7F);
    lit(3, 7'h12, 3);
    gap();

    // Write to another entry while digit 4 is lit: seg unaffected.
    lit(4, 7'h7F, 1);
    cyc(1'b1, 1'b1, 3'd1, 7'h79, 8'hEF, 7'h7F);
    lit(4, 7'h7F, 2);
    gap();

    // Drop en after cycle 2 of digit 5, then resume digit 5 for a full period.
    lit(5, 7'h7F, 2);
    cyc(1'b0, 1'b0, 3'd0, 7'h00, 8'hFF, 7'h7F);
    cyc(1'b0, 1'b0, 3'd0, 7'h00, 8'hFF, 7'h7F);
    lit(5, 7'h7F, 4);
    gap();
    lit(6, 7'h7F, 4);
    cyc(1'b1, 1'b0, 3'd0, 7'h00, 8'hFF, 7'h7F);  // first guard cycle

    // Asynchronous reset mid-guard.
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("guard_rst_an", an, 8'hFF);
    chk("guard_rst_seg", {1'b0, seg}, 8'h7F);
    chk("guard_rst_idx", {5'd0, idx}, 8'h00);
    @(negedge clk);

    // Release with en=1: digit 0 first; every store entry reads back blank.
    for (int d = 0; d < 8; d++) begin
      lit(d, 7'h7F, 4);
      gap();
    end
    lit(0, 7'h7F, 2);

    // Asynchronous reset mid-show blanks without waiting for an edge.
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("show_rst_an", an, 8'hFF);
    chk("show_rst_seg", {1'b0, seg}, 8'h7F);

    @(negedge clk);
    #1;
    chk("queue_drained", 8'(exp_q.size()), 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 The block SHALL have parameter DIV, default 50000, setting the cycles each digit is lit (legal range 1..2^20).
REQ-002 The block SHALL have parameter GUARD, default 4, setting the blanking cycles between digits (legal range 0..255).
REQ-003 clk  input  1  the single clock; all state changes occur on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 en  input  1  scan enable; 0 blanks the display.
REQ-006 wr_en  input  1  write strobe for the pattern store.
REQ-007 wr_idx  input  3  digit index written when wr_en=1.
REQ-008 wr_seg  input  7  active-low segment pattern, as produced by the 4-bit-to-7-segment decoder.
REQ-009 an  output  8  active-low digit enables; an[i] drives digit i.
REQ-010 seg  output  7  active-low segment lines shared by all digits.
REQ-011 idx  output  3  index of the digit currently scheduled.

Function
REQ-012 The block SHALL hold an 8-entry x 7-bit pattern store; wr_en=1 SHALL write wr_seg into entry wr_idx at the clock edge.
REQ-013 The state machine SHALL have states IDLE, SHOW and GUARD.
REQ-014 In IDLE, an SHALL be 8'hFF and seg SHALL be 7'h7F.
- Transition: en=1 -> SHOW at the next edge, with idx unchanged and the prescaler at 0.
REQ-015 In SHOW, an SHALL have only bit idx low, and seg SHALL equal store[idx].
- The state SHALL last exactly DIV cycles.
- Exit: to GUARD, or directly to SHOW with idx+1 when GUARD=0.
REQ-016 In GUARD, an SHALL be 8'hFF and seg SHALL be 7'h7F for exactly GUARD cycles; the block SHALL then enter SHOW with idx+1.
REQ-017 idx SHALL wrap from 7 to 0.
REQ-018 en=0 in any state SHALL force IDLE at the next edge.
- idx is retained; the prescaler is cleared.
- Re-enabling resumes at the same digit with a full DIV period.
REQ-019 an and seg SHALL be registered and SHALL change on the same edge as the state register, with no combinational path from inputs to outputs.
REQ-020 A write to the entry currently shown SHALL appear on seg at the edge after the write edge (one-cycle latency).
- A write to any other entry SHALL leave seg unchanged.
REQ-021 When a write and a digit switch occur on the same edge, the next lit digit SHALL show the value read from the store at that edge (pre-write).
- The post-write value SHALL appear one cycle later.
REQ-022 The prescaler SHALL be ceil(log2(DIV+1)) bits wide.
- It SHALL count 0..DIV-1 in SHOW and 0..GUARD-1 in GUARD.
- It SHALL never run past its terminal count.
REQ-023 At most one bit of an SHALL be low in any cycle.

Reset
REQ-024 Asserting rst SHALL immediately, independent of clk, set:
- state=IDLE, idx=0, prescaler=0
- an=8'hFF, seg=7'h7F
- all 8 store entries=7'h7F (blank)
REQ-025 Reset mid-SHOW or mid-GUARD SHALL abandon the current period.
- After deassertion with en=1, SHOW of digit 0 SHALL begin at the first edge.

Structure
REQ-026 The shared package seg_pkg SHALL hold:
- SEG_BLANK = 7'h7F
- NDIG = 8
- the state enumeration {IDLE, SHOW, GUARD}
REQ-027 The prescaler SHALL be one sub-module, tick_gen, with a load value, clear and enable inputs and a terminal-count pulse output.
REQ-028 The pattern store SHALL be plain registers, not inferred RAM.

Verification (bench uses DIV=4, GUARD=2)
REQ-029 Reset release, en=1, no writes:
- an cycles FE, FF, FF, FD, ... (FE lasts 4 cycles; each FF pair is the guard).
- seg stays 7F throughout.
REQ-030 Write store[0]=7'h40 and store[7]=7'h78, then en=1:
- seg=40 while an=FE; seg=78 while an=7F.
- After an=7F the sequence wraps to an=FE.
REQ-031 While digit 2 is lit, write store[2]=7'h24:
- seg changes to 24 exactly one edge later.
- an stays FB for the remainder of its 4 cycles.
REQ-032 Drop en to 0 at cycle 2 of digit 5:
- Next edge gives an=FF, seg=7F.
- Re-enable resumes digit 5 for a full 4 cycles.
REQ-033 Assert rst mid-GUARD after digit 6:
- Outputs go FF/7F asynchronously and all store entries read back blank.
- After release with en=1, digit 0 is lit first.
REQ-034 Across all scenarios, an assertion SHALL check that an never has more than one low bit.
